hbram_host_arbiter: RTL



---
 rtl/hbram_arb_pkg.sv | 18 +
 rtl/hbram_rr_pick.sv | 18 +
 rtl/hbram_host_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hbram_arb_pkg.sv
// Shared types and helpers for the HyperRAM host-port arbiter.
// Beat-accept rule is shared so the top and any future ports agree on it.
package hbram_arb_pkg;

  localparam int PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // A read beat completes on rdav, a write beat on wrdy.
  function automatic logic beat_accept(input logic rwen, input logic wrdy, input logic rdav);
    return rwen ? rdav : wrdy;
  endfunction

endpackage

// File: rtl/hbram_rr_pick.sv
// Two-way winner picker: a lone requester wins; ties go to port 0 in fixed
// priority mode, otherwise to the port that did not own the bus last.
module hbram_rr_pick #(
  parameter int PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = (PRIORITY != 0) ? 1'b0 : ~last_owner;
    end
  end

endmodule

// File: rtl/hbram_host_arbiter.sv
// Shares one HyperRAM controller host port between two burst requesters,
// granting whole bursts only after calibration, with a beat-limit watchdog.
module hbram_host_arbiter
  import hbram_arb_pkg::*;
#(
  parameter int RAM_DBW   = 8,
  parameter int RAM_ABW   = 25,
  parameter int PRIORITY  = 0,
  parameter int MAX_BEATS = 256
) (
  input  logic                   ram_clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic [RAM_ABW-1:0]     m0_addr,
  input  logic                   m0_btype,
  input  logic                   m0_atype,
  input  logic                   m0_rwen,
  input  logic                   m0_last,
  input  logic [RAM_DBW*2-1:0]   m0_wdata,
  input  logic [RAM_DBW/4-1:0]   m0_wdm,
  output logic                   m0_gnt,
  output logic                   m0_wrdy,
  output logic                   m0_rdav,
  output logic [RAM_DBW*2-1:0]   m0_rdata,
  input  logic                   m1_req,
  input  logic [RAM_ABW-1:0]     m1_addr,
  input  logic                   m1_btype,
  input  logic                   m1_atype,
  input  logic                   m1_rwen,
  input  logic                   m1_last,
  input  logic [RAM_DBW*2-1:0]   m1_wdata,
  input  logic [RAM_DBW/4-1:0]   m1_wdm,
  output logic                   m1_gnt,
  output logic                   m1_wrdy,
  output logic                   m1_rdav,
  output logic [RAM_DBW*2-1:0]   m1_rdata,
  output logic                   h_req,
  output logic                   h_last,
  output logic [RAM_ABW-1:0]     h_addr,
  output logic                   h_btype,
  output logic                   h_atype,
  output logic                   h_rwen,
  output logic [RAM_DBW/4-1:0]   h_wdm,
  output logic [RAM_DBW*2-1:0]   h_wdata,
  input  logic                   h_wrdy,
  input  logic                   h_rdav,
  input  logic                   h_mrdy,
  input  logic [RAM_DBW*2-1:0]   h_rdata,
  output logic                   owner,
  output logic                   busy,
  output logic                   wdog_err
);

  localparam int DW      = RAM_DBW * 2;
  localparam int MW      = RAM_DBW / 4;
  localparam int CNT_W   = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam int LAST_I  = (MAX_BEATS > 0) ? MAX_BEATS - 1 : 0;
  localparam bit WDOG_ON = (MAX_BEATS != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  logic [PORTS-1:0]   req_vec, last_vec, rwen_vec, btype_vec, atype_vec;
  logic [RAM_ABW-1:0] addr_arr  [PORTS];
  logic [DW-1:0]      wdata_arr [PORTS];
  logic [MW-1:0]      wdm_arr   [PORTS];
  logic [PORTS-1:0]   gnt_vec, wrdy_vec, rdav_vec;

  arb_state_t         state_reg, state_next;
  logic               owner_reg, owner_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               winner, grant_now, accept, wdog_hit;

  assign req_vec      = {m1_req, m0_req};
  assign last_vec     = {m1_last, m0_last};
  assign rwen_vec     = {m1_rwen, m0_rwen};
  assign btype_vec    = {m1_btype, m0_btype};
  assign atype_vec    = {m1_atype, m0_atype};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;
  assign wdm_arr[0]   = m0_wdm;
  assign wdm_arr[1]   = m1_wdm;

  hbram_rr_pick #(
    .PRIORITY (PRIORITY)
  ) u_pick (
    .req        (req_vec),
    .last_owner (owner_reg),
    .winner     (winner)
  );

  assign grant_now = (state_reg == IDLE) && h_mrdy && (|req_vec);
  assign accept    = (state_reg == BUSY) &&
                     beat_accept(rwen_vec[owner_reg], h_wrdy, h_rdav);
  // A burst that ends normally on the limit beat is not a watchdog release.
  assign wdog_hit  = WDOG_ON && accept && req_vec[owner_reg] &&
                     !last_vec[owner_reg] && (cnt_reg == CNT_LAST);

  always_ff @(posedge ram_clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE: begin
        if (grant_now) begin
          state_next = BUSY;
          owner_next = winner;
        end
      end
      BUSY: begin
        if ((accept && last_vec[owner_reg]) || !req_vec[owner_reg] || wdog_hit) begin
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (grant_now) begin
      cnt_next = '0;
    end else if (accept && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    gnt_vec  = '0;
    wrdy_vec = '0;
    rdav_vec = '0;
    h_req    = 1'b0;
    h_last   = 1'b0;
    h_addr   = '0;
    h_btype  = 1'b0;
    h_atype  = 1'b0;
    h_rwen   = 1'b0;
    h_wdm    = '0;
    h_wdata  = '0;
    busy     = 1'b0;
    wdog_err = 1'b0;
    if (state_reg == BUSY) begin
      busy                = 1'b1;
      gnt_vec[owner_reg]  = 1'b1;
      wrdy_vec[owner_reg] = h_wrdy;
      rdav_vec[owner_reg] = h_rdav;
      h_req               = req_vec[owner_reg];
      h_last              = last_vec[owner_reg];
      h_addr              = addr_arr[owner_reg];
      h_btype             = btype_vec[owner_reg];
      h_atype             = atype_vec[owner_reg];
      h_rwen              = rwen_vec[owner_reg];
      h_wdm               = wdm_arr[owner_reg];
      h_wdata             = wdata_arr[owner_reg];
      wdog_err            = wdog_hit;
    end
  end

  assign m0_gnt   = gnt_vec[0];
  assign m1_gnt   = gnt_vec[1];
  assign m0_wrdy  = wrdy_vec[0];
  assign m1_wrdy  = wrdy_vec[1];
  assign m0_rdav  = rdav_vec[0];
  assign m1_rdav  = rdav_vec[1];
  assign m0_rdata = h_rdata;
  assign m1_rdata = h_rdata;
  assign owner    = owner_reg;

endmodule
